// File: rtl/face_detect_mac_pkg.sv
// Shared types and constant helpers for the face-detection multiply-accumulate pipeline.
// Covers product width/extension rules, saturation bounds and the per-beat framing flags.
package face_detect_mac_pkg;

  typedef struct packed {
    logic first;
    logic last;
  } flag_t;

  function automatic int prod_width(input int aw, input int bw);
    return aw + bw;
  endfunction

  function automatic bit prod_signed(input bit sa, input bit sb);
    return sa | sb;
  endfunction

  // An operand only sign-extends when it is itself two's complement.
  function automatic logic ext_bit(input logic msb, input bit is_signed);
    return msb & is_signed;
  endfunction

  // Bounds are returned in 64 bits; callers keep the low w bits.
  function automatic logic [63:0] sat_max(input int w, input bit s);
    logic [63:0] one;
    one = 64'd1;
    return s ? ((one << (w - 1)) - 64'd1) : ((one << w) - 64'd1);
  endfunction

  function automatic logic [63:0] sat_min(input int w, input bit s);
    logic [63:0] one;
    one = 64'd1;
    return s ? (64'd0 - (one << (w - 1))) : 64'd0;
  endfunction

endpackage

// File: rtl/face_detect_mul_acc_pipe_dsp.sv
// Enable-gated multiplier with NUM_REG output registers (the DSP pipeline stages).
// Operands are extended to the full product width so one signed multiply serves every mode.
module face_detect_mul_acc_pipe_dsp
  import face_detect_mac_pkg::*;
#(
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 10,
  parameter int SIGNED_A = 0,
  parameter int SIGNED_B = 0,
  parameter int NUM_REG  = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    i_ce,
  input  logic [A_WIDTH-1:0]                      i_a,
  input  logic [B_WIDTH-1:0]                      i_b,
  output logic [prod_width(A_WIDTH, B_WIDTH)-1:0] o_prod
);

  localparam int FW = prod_width(A_WIDTH, B_WIDTH);

  logic                 w_a_msb;
  logic                 w_b_msb;
  logic signed [FW-1:0] w_a_ext;
  logic signed [FW-1:0] w_b_ext;
  logic signed [FW-1:0] w_prod;

  assign w_a_msb = ext_bit(i_a[A_WIDTH-1], SIGNED_A != 0);
  assign w_b_msb = ext_bit(i_b[B_WIDTH-1], SIGNED_B != 0);
  assign w_a_ext = {{B_WIDTH{w_a_msb}}, i_a};
  assign w_b_ext = {{A_WIDTH{w_b_msb}}, i_b};
  // The true product always fits FW bits, so the modular result is exact.
  assign w_prod  = w_a_ext * w_b_ext;

  generate
    if (NUM_REG == 0) begin : g_comb
      assign o_prod = w_prod;
    end else begin : g_pipe
      logic [FW-1:0] r_pipe [NUM_REG];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_REG; i++) r_pipe[i] <= '0;
        end else if (i_ce) begin
          r_pipe[0] <= w_prod;
          for (int i = 1; i < NUM_REG; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign o_prod = r_pipe[NUM_REG-1];
    end
  endgenerate

endmodule

// File: rtl/face_detect_mul_acc_pipe.sv
// Handshaked multiply-accumulate pipeline: operand stage, DSP stages, then the accumulator stage.
// A single global advance moves every stage together, so stalls never compress bubbles.
module face_detect_mul_acc_pipe
  import face_detect_mac_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 10,
  parameter int P_WIDTH   = 25,
  parameter int ACC_WIDTH = 32,
  parameter int NUM_STAGE = 4,
  parameter int SIGNED_A  = 0,
  parameter int SIGNED_B  = 0,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 in_first,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [P_WIDTH-1:0]   p,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 out_last,
  output logic                 acc_ovf
);

  localparam int   FW    = prod_width(A_WIDTH, B_WIDTH);
  localparam bit   PSIGN = prod_signed(SIGNED_A != 0, SIGNED_B != 0);
  localparam int   SW    = ((FW > ACC_WIDTH) ? FW : ACC_WIDTH) + 2;
  localparam logic [63:0] MAX64 = sat_max(ACC_WIDTH, PSIGN);
  localparam logic [63:0] MIN64 = sat_min(ACC_WIDTH, PSIGN);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = MAX64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = MIN64[ACC_WIDTH-1:0];
  localparam logic signed [SW-1:0] WIDE_MAX = {{(SW-ACC_WIDTH){1'b0}}, ACC_MAX};
  localparam logic signed [SW-1:0] WIDE_MIN =
    {{(SW-ACC_WIDTH){PSIGN & ACC_MIN[ACC_WIDTH-1]}}, ACC_MIN};

  logic                 w_adv;
  logic [A_WIDTH-1:0]   r_a;
  logic [B_WIDTH-1:0]   r_b;
  logic [NUM_STAGE-1:1] r_vld;
  flag_t                r_flg [NUM_STAGE-1:1];
  logic [FW-1:0]        w_prod;
  logic [P_WIDTH-1:0]   w_p;
  logic                 w_first;
  logic signed [SW-1:0] w_prod_wide;
  logic signed [SW-1:0] w_base;
  logic signed [SW-1:0] w_sum;
  logic                 w_hi;
  logic                 w_lo;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_ovf_next;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_ovf;
  logic [P_WIDTH-1:0]   r_p;
  logic [ACC_WIDTH-1:0] r_acc;

  // Advance depends only on ce and the output handshake, never on in_valid.
  assign w_adv    = ce & (~r_out_valid | out_ready);
  assign in_ready = w_adv & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
      r_a   <= '0;
      r_b   <= '0;
      for (int k = 1; k < NUM_STAGE; k++) r_flg[k] <= '0;
    end else if (w_adv) begin
      r_vld[1] <= in_valid;
      r_a      <= a;
      r_b      <= b;
      r_flg[1] <= '{first: in_first, last: in_last};
      for (int k = 2; k < NUM_STAGE; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_flg[k] <= r_flg[k-1];
      end
    end
  end

  face_detect_mul_acc_pipe_dsp #(
    .A_WIDTH  (A_WIDTH),
    .B_WIDTH  (B_WIDTH),
    .SIGNED_A (SIGNED_A),
    .SIGNED_B (SIGNED_B),
    .NUM_REG  (NUM_STAGE - 2)
  ) u_dsp (
    .clk    (clk),
    .reset  (reset),
    .i_ce   (w_adv),
    .i_a    (r_a),
    .i_b    (r_b),
    .o_prod (w_prod)
  );

  generate
    if (P_WIDTH > FW) begin : g_p_ext
      assign w_p = {{(P_WIDTH-FW){PSIGN & w_prod[FW-1]}}, w_prod};
    end else if (P_WIDTH == FW) begin : g_p_same
      assign w_p = w_prod;
    end else begin : g_p_trunc
      assign w_p = w_prod[P_WIDTH-1:0];
    end
  endgenerate

  // Sum in a width that holds any result exactly, then compare against the accumulator range.
  assign w_first     = r_flg[NUM_STAGE-1].first;
  assign w_prod_wide = {{(SW-FW){PSIGN & w_prod[FW-1]}}, w_prod};
  assign w_base      = w_first ? '0 : {{(SW-ACC_WIDTH){PSIGN & r_acc[ACC_WIDTH-1]}}, r_acc};
  assign w_sum       = w_base + w_prod_wide;
  assign w_hi        = w_sum > WIDE_MAX;
  assign w_lo        = w_sum < WIDE_MIN;
  assign w_ovf_next  = w_hi | w_lo | (~w_first & r_ovf);

  always_comb begin
    w_acc_next = w_sum[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && w_hi) w_acc_next = ACC_MAX;
    else if ((SATURATE != 0) && w_lo) w_acc_next = ACC_MIN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
      r_p         <= '0;
      r_acc       <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_vld[NUM_STAGE-1];
      if (r_vld[NUM_STAGE-1]) begin
        r_p        <= w_p;
        r_acc      <= w_acc_next;
        r_out_last <= r_flg[NUM_STAGE-1].last;
        r_ovf      <= w_ovf_next;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign acc_ovf   = r_ovf;
  assign p         = r_p;
  assign acc       = r_acc;

endmodule

// File: tb/tb_face_detect_mul_acc_pipe.sv
// Directed, table-driven bench: four pipeline configurations share one stimulus bus,
// and a selector routes the instance under test to the checker.
module tb_face_detect_mul_acc_pipe;

  localparam int NUM_STAGE = 4;

  logic        clk = 1'b0;
  logic        reset, ce, in_valid, in_first, in_last, out_ready;
  logic [15:0] a;
  logic [9:0]  b;

  logic        rdy0, ov0, ol0, of0;
  logic [24:0] p0;
  logic [31:0] acc0;
  logic        rdy1, ov1, ol1, of1;
  logic [15:0] p1;
  logic [31:0] acc1;
  logic        rdy2, ov2, ol2, of2;
  logic [24:0] p2;
  logic [24:0] acc2;
  logic        rdy3, ov3, ol3, of3;
  logic [24:0] p3;
  logic [24:0] acc3;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        selReady, selValid, selLast, selOvf;
  logic [31:0] selP, selAcc;

  typedef struct {
    int a; int b; int first; int last;
    int expP; int expAcc; int expLast; int expOvf;
  } vec_t;
  vec_t vecs [0:31];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  face_detect_mul_acc_pipe dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy0),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(ov0),
    .out_ready(out_ready), .p(p0), .acc(acc0), .out_last(ol0), .acc_ovf(of0));

  face_detect_mul_acc_pipe #(.A_WIDTH(8), .B_WIDTH(8), .P_WIDTH(16),
                             .SIGNED_A(1), .SIGNED_B(1)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy1),
    .a(a[7:0]), .b(b[7:0]), .in_first(in_first), .in_last(in_last), .out_valid(ov1),
    .out_ready(out_ready), .p(p1), .acc(acc1), .out_last(ol1), .acc_ovf(of1));

  face_detect_mul_acc_pipe #(.ACC_WIDTH(25), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(ov2),
    .out_ready(out_ready), .p(p2), .acc(acc2), .out_last(ol2), .acc_ovf(of2));

  face_detect_mul_acc_pipe #(.ACC_WIDTH(25), .SATURATE(0)) dut3 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy3),
    .a(a), .b(b), .in_first(in_first), .in_last(in_last), .out_valid(ov3),
    .out_ready(out_ready), .p(p3), .acc(acc3), .out_last(ol3), .acc_ovf(of3));

  // Route the instance currently being checked onto common 32-bit observation signals
  always_comb begin
    selReady = rdy0; selValid = ov0; selLast = ol0; selOvf = of0;
    selP = 32'(p0); selAcc = acc0;
    case (sel)
      1: begin
        selReady = rdy1; selValid = ov1; selLast = ol1; selOvf = of1;
        selP = 32'(p1); selAcc = acc1;
      end
      2: begin
        selReady = rdy2; selValid = ov2; selLast = ol2; selOvf = of2;
        selP = 32'(p2); selAcc = 32'(acc2);
      end
      3: begin
        selReady = rdy3; selValid = ov3; selLast = ol3; selOvf = of3;
        selP = 32'(p3); selAcc = 32'(acc3);
      end
      default: ;
    endcase
  end

  // Every comparison funnels through here so the counters stay in one place
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic setVec(input int i, input int va, input int vb, input int vf, input int vl,
                        input int vp, input int vacc, input int vlast, input int vovf);
    vecs[i] = '{a: va, b: vb, first: vf, last: vl,
                expP: vp, expAcc: vacc, expLast: vlast, expOvf: vovf};
  endtask

  // Present one beat from the table on the shared input bus
  task automatic applyStimulus(input int idx);
    in_valid = 1'b1;
    a        = 16'(vecs[idx].a);
    b        = 10'(vecs[idx].b);
    in_first = 1'(vecs[idx].first);
    in_last  = 1'(vecs[idx].last);
  endtask

  // Stream n table entries into the selected instance; mode 1 toggles out_ready 1,0,0,...
  task automatic runStream(input int dsel, input int start, input int n, input int mode);
    int sent, got, k;
    int acceptEdge [32];
    sel = dsel; sent = 0; got = 0; k = 0;
    while (got < n && k < 400) begin
      @(negedge clk);
      out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      #1;
      if (selValid) begin
        if (!out_ready) checkOutput($sformatf("stall_in_ready[%0d]", start + got),
                                    32'(selReady), 0);
        checkOutput($sformatf("p[%0d]", start + got), selP, vecs[start+got].expP);
        checkOutput($sformatf("acc[%0d]", start + got), selAcc, vecs[start+got].expAcc);
        checkOutput($sformatf("last[%0d]", start + got), 32'(selLast), vecs[start+got].expLast);
        checkOutput($sformatf("ovf[%0d]", start + got), 32'(selOvf), vecs[start+got].expOvf);
        if (out_ready) begin
          if (mode == 0)
            checkOutput($sformatf("latency[%0d]", start + got), cyc - acceptEdge[got],
                        NUM_STAGE - 1);
          got++;
        end
      end
      if (sent < n) begin
        applyStimulus(start + sent);
        if (selReady) begin
          acceptEdge[sent] = cyc + 1;
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      k++;
    end
    if (got != n) checkOutput("stream_timeout", got, n);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1 checkOutput("no_extra_beat", 32'(selValid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; a = '0; b = '0;

    // Defaults, unsigned, 25-bit p truncates the 26-bit product
    setVec(0,  1000,  3,    1, 0, 3000,     3000,     0, 0);
    setVec(1,  65535, 1023, 0, 1, 33487873, 67045305, 1, 0);
    setVec(2,  7,     0,    0, 0, 0,        67045305, 0, 0);
    setVec(3,  2,     5,    1, 1, 10,       10,       1, 0);
    setVec(4,  65535, 1023, 1, 0, 33487873, 67042305, 0, 0);
    setVec(5,  12345, 678,  0, 1, 8369910,  75412215, 1, 0);
    setVec(6,  0,     1023, 1, 0, 0,        0,        0, 0);
    setVec(7,  100,   9,    0, 1, 900,      900,      1, 0);
    // Signed 8x8 into 16-bit p
    setVec(8,  'h80,  'h80, 1, 0, 16384,    16384,         0, 0);
    setVec(9,  'hFF,  'h05, 0, 1, 65531,    16379,         1, 0);
    setVec(10, 'h7F,  'h80, 1, 0, 49280,    32'hFFFFC080,  0, 0);
    setVec(11, 'h7F,  'h7F, 0, 1, 16129,    32'hFFFFFF81,  1, 0);
    // 25-bit accumulator, saturating
    setVec(12, 65535, 511,  1, 0, 33488385, 33488385, 0, 0);
    setVec(13, 255,   255,  0, 0, 65025,    33553410, 0, 0);
    setVec(14, 255,   5,    0, 0, 1275,     33554431, 0, 1);
    setVec(15, 65535, 1023, 0, 1, 33487873, 33554431, 1, 1);
    setVec(16, 10,    10,   1, 0, 100,      100,      0, 0);
    setVec(17, 1000,  1000, 0, 1, 1000000,  1000100,  1, 0);
    // 25-bit accumulator, wrapping
    setVec(18, 65535, 511,  1, 0, 33488385, 33488385, 0, 0);
    setVec(19, 255,   255,  0, 0, 65025,    33553410, 0, 0);
    setVec(20, 255,   5,    0, 0, 1275,     253,      0, 1);
    setVec(21, 65535, 1023, 0, 1, 33487873, 33488126, 1, 1);
    setVec(22, 10,    10,   1, 0, 100,      100,      0, 0);
    setVec(23, 1000,  1000, 0, 1, 1000000,  1000100,  1, 0);
    // First beat after a reset, no in_first: accumulates onto zero
    setVec(24, 3,     4,    0, 1, 12,       12,       1, 0);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(selValid), 0);
    checkOutput("reset_p", selP, 0);
    checkOutput("reset_acc", selAcc, 0);
    checkOutput("reset_in_ready", 32'(selReady), 0);
    checkOutput("reset_ovf", 32'(selOvf), 0);
    @(negedge clk);
    reset = 1'b0;

    runStream(0, 0, 8, 0);
    runStream(1, 8, 4, 0);
    runStream(2, 12, 6, 0);
    runStream(3, 18, 6, 0);
    runStream(0, 0, 8, 1);

    // Reset with three beats in flight, then hold ce low
    sel = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    #1 checkOutput("in_ready_during_reset", 32'(selReady), 0);
    @(negedge clk);
    reset = 1'b0;
    ce = 1'b0;
    applyStimulus(0);
    #1;
    checkOutput("post_reset_valid", 32'(selValid), 0);
    checkOutput("post_reset_p", selP, 0);
    checkOutput("post_reset_acc", selAcc, 0);
    checkOutput("post_reset_in_ready", 32'(selReady), 0);
    repeat (5) begin
      @(negedge clk);
      #1;
      checkOutput("ce_low_valid", 32'(selValid), 0);
      checkOutput("ce_low_in_ready", 32'(selReady), 0);
      checkOutput("ce_low_acc", selAcc, 0);
    end
    @(negedge clk);
    ce = 1'b1;
    in_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1 checkOutput("discarded_beat", 32'(selValid), 0);
    end

    // A held output beat must survive ce low even with out_ready high
    @(negedge clk);
    applyStimulus(24);
    w = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      w++;
    end while (!selValid && w < 20);
    checkOutput("freeze_valid", 32'(selValid), 1);
    ce = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      checkOutput("freeze_hold_valid", 32'(selValid), 1);
      checkOutput("freeze_p", selP, 12);
      checkOutput("freeze_acc", selAcc, 12);
      checkOutput("freeze_last", 32'(selLast), 1);
      checkOutput("freeze_in_ready", 32'(selReady), 0);
    end
    ce = 1'b1;
    @(negedge clk);
    #1 checkOutput("consumed_after_ce", 32'(selValid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
